// File: rtl/matrix_addsub_arbiter_if.sv
// Bundle of request/response and shared-unit control signals for the
// matrix add/subtract arbiter. The slave modport is the arbiter's view;
// the master modport is the view of the requesters plus the shared unit.
interface matrix_addsub_arbiter_if #(
  parameter int NUM_REQ = 3
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] req_done;
  logic [NUM_REQ-1:0] req_err;
  logic               unit_start;
  logic               unit_op;
  logic               unit_done;
  logic               unit_abort;
  logic               busy;
  logic               err_sticky;

  modport slave (
    input  req, req_op, unit_done,
    output grant, grant_idx, req_done, req_err,
           unit_start, unit_op, unit_abort, busy, err_sticky
  );

  modport master (
    output req, req_op, unit_done,
    input  grant, grant_idx, req_done, req_err,
           unit_start, unit_op, unit_abort, busy, err_sticky
  );
endinterface

// File: rtl/matrix_addsub_arbiter.sv
// Round-robin arbiter sharing one element-wise matrix add/subtract unit
// between EKF pipeline stages. Issues start/op to the unit, waits for done,
// and returns a done or error pulse to the grantee. A watchdog aborts
// transactions the unit never completes. All outputs are registered.
module matrix_addsub_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_addsub_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               unit_op_q, unit_op_d;
  logic [NUM_REQ-1:0] req_done_q, req_done_d;
  logic [NUM_REQ-1:0] req_err_q, req_err_d;
  logic               unit_start_q, unit_start_d;
  logic               unit_abort_q, unit_abort_d;
  logic               busy_q, busy_d;
  logic               err_sticky_q, err_sticky_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic               done_hit;
  logic               timeout_hit;

  // Completion beats the watchdog when both land in the same WAIT cycle.
  assign done_hit    = (state_q == S_WAIT) && bus.unit_done;
  assign timeout_hit = (state_q == S_WAIT) && !bus.unit_done && (timer_q == TMR_LAST);

  // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!sel_valid && bus.req[cand_idx]) begin
        sel_valid = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sel_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (done_hit || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath state.
  always_comb begin
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    unit_op_d    = unit_op_q;
    req_done_d   = '0;
    req_err_d    = '0;
    unit_start_d = 1'b0;
    unit_abort_d = 1'b0;
    busy_d       = (state_d != S_IDLE);
    err_sticky_d = err_sticky_q;
    rr_ptr_d     = rr_ptr_q;
    timer_d      = timer_q;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          grant_idx_d      = sel_idx;
          unit_op_d        = bus.req_op[sel_idx];
          unit_start_d     = 1'b1;
        end
      end
      S_ISSUE: begin
        // Done is not looked at here; the unit cannot finish in zero cycles.
        timer_d = '0;
      end
      S_WAIT: begin
        if (done_hit) begin
          req_done_d[grant_idx_q] = 1'b1;
        end else if (timeout_hit) begin
          req_err_d[grant_idx_q] = 1'b1;
          unit_abort_d           = 1'b1;
          err_sticky_d           = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RESP: begin
        grant_d  = '0;
        rr_ptr_d = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      unit_op_q    <= 1'b0;
      req_done_q   <= '0;
      req_err_q    <= '0;
      unit_start_q <= 1'b0;
      unit_abort_q <= 1'b0;
      busy_q       <= 1'b0;
      err_sticky_q <= 1'b0;
      rr_ptr_q     <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      unit_op_q    <= unit_op_d;
      req_done_q   <= req_done_d;
      req_err_q    <= req_err_d;
      unit_start_q <= unit_start_d;
      unit_abort_q <= unit_abort_d;
      busy_q       <= busy_d;
      err_sticky_q <= err_sticky_d;
      rr_ptr_q     <= rr_ptr_d;
      timer_q      <= timer_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_idx  = grant_idx_q;
  assign bus.unit_op    = unit_op_q;
  assign bus.req_done   = req_done_q;
  assign bus.req_err    = req_err_q;
  assign bus.unit_start = unit_start_q;
  assign bus.unit_abort = unit_abort_q;
  assign bus.busy       = busy_q;
  assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_matrix_addsub_arbiter.sv
// Self-checking bench for matrix_addsub_arbiter. A transaction-level model
// tracks the rotation pointer and sticky error; a small unit model answers
// each start after a chosen latency (or never).
module tb_matrix_addsub_arbiter;
  localparam int N  = 3;
  localparam int T  = 64;
  localparam int IW = 2;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   m_rr;
  bit   m_err;

  matrix_addsub_arbiter_if #(.NUM_REQ(N)) bus ();

  matrix_addsub_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Next grantee: first requester in rotation order starting at the pointer.
  function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
    int order[$];
    for (int i = 0; i < N; i++) order.push_back((ptr + i) % N);
    foreach (order[i]) if (mask[IW'(order[i])]) return order[i];
    return -1;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.req_op = '0;
    bus.unit_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_rr = 0;
    m_err = 1'b0;
  endtask

  // Run one transaction from the current req/req_op. lat in 1..T answers
  // with unit_done lat cycles after start; otherwise the unit stays silent.
  task automatic serve(input int lat, input bit drop, input int flip_at, output int waited);
    int            exp;
    logic [N-1:0]  exp_oh;
    logic          exp_op;
    bit            found;
    bit            ok;
    bit            bad;
    int            n;
    exp    = model_pick(bus.req, m_rr);
    exp_oh = (exp < 0) ? '0 : (N'(1) << exp);
    exp_op = (exp < 0) ? 1'b0 : bus.req_op[IW'(exp)];
    found  = 1'b0;
    waited = 0;
    for (int t = 0; t < 8 && !found; t++) begin
      tick();
      waited++;
      if (bus.unit_start === 1'b1) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL start_seen: unit_start got 0 want 1 within 8 cycles");
      return;
    end
    tests_run++;
    if (bus.grant !== exp_oh) begin
      tests_failed++;
      $display("FAIL issue_grant: got %b want %b", bus.grant, exp_oh);
    end
    tests_run++;
    if (bus.grant_idx !== IW'(exp)) begin
      tests_failed++;
      $display("FAIL issue_grant_idx: got %0d want %0d", bus.grant_idx, exp);
    end
    tests_run++;
    if (bus.unit_op !== exp_op || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL issue_op_busy: got op=%b busy=%b want op=%b busy=1", bus.unit_op, bus.busy, exp_op);
    end
    ok  = (lat >= 1 && lat <= T);
    n   = ok ? lat : T;
    bad = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (bus.unit_start !== 1'b0 || bus.req_done !== '0 || bus.req_err !== '0 ||
          bus.unit_abort !== 1'b0 || bus.grant !== exp_oh || bus.unit_op !== exp_op)
        bad = 1'b1;
      bus.unit_done = ok && (k == lat);
      if (k == flip_at) begin
        bus.req[IW'(exp)]    = 1'b0;
        bus.req_op[IW'(exp)] = ~bus.req_op[IW'(exp)];
      end
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL wait_stable: outputs changed during WAIT (lat=%0d) want grant=%b op=%b no pulses", lat, exp_oh, exp_op);
    end
    tick();
    bus.unit_done = 1'b0;
    m_err = m_err | !ok;
    tests_run++;
    if (bus.req_done !== (ok ? exp_oh : '0) || bus.req_err !== (ok ? '0 : exp_oh)) begin
      tests_failed++;
      $display("FAIL resp_pulse: got done=%b err=%b want done=%b err=%b",
               bus.req_done, bus.req_err, ok ? exp_oh : '0, ok ? '0 : exp_oh);
    end
    tests_run++;
    if (bus.unit_abort !== !ok || bus.err_sticky !== m_err || bus.grant !== exp_oh) begin
      tests_failed++;
      $display("FAIL resp_abort_sticky: got abort=%b sticky=%b grant=%b want abort=%b sticky=%b grant=%b",
               bus.unit_abort, bus.err_sticky, bus.grant, !ok, m_err, exp_oh);
    end
    if (drop) bus.req = '0;
    m_rr = (exp + 1) % N;
    tick();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.grant !== '0 || bus.req_done !== '0 ||
        bus.req_err !== '0 || bus.unit_abort !== 1'b0 || bus.unit_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_quiet: got busy=%b grant=%b done=%b err=%b abort=%b start=%b want all 0",
               bus.busy, bus.grant, bus.req_done, bus.req_err, bus.unit_abort, bus.unit_start);
    end
  endtask

  task automatic check_all_zero(input string tag);
    tests_run++;
    if (bus.grant !== '0 || bus.grant_idx !== '0 || bus.req_done !== '0 || bus.req_err !== '0 ||
        bus.unit_start !== 1'b0 || bus.unit_op !== 1'b0 || bus.unit_abort !== 1'b0 ||
        bus.busy !== 1'b0 || bus.err_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: got grant=%b idx=%0d done=%b err=%b start=%b op=%b abort=%b busy=%b sticky=%b want all 0",
               tag, bus.grant, bus.grant_idx, bus.req_done, bus.req_err, bus.unit_start,
               bus.unit_op, bus.unit_abort, bus.busy, bus.err_sticky);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_all_zero("reset_state");
    tick();
    check_all_zero("idle_no_req");
  endtask

  task automatic test_single();
    int w;
    apply_reset();
    bus.unit_done = 1'b1;
    tick();
    bus.unit_done = 1'b0;
    tick();
    check_all_zero("stray_done_idle");
    bus.req    = 3'b001;
    bus.req_op = 3'b000;
    serve(18, 1'b1, 0, w);
    tests_run++;
    if (w !== 1) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d cycles want 1", w);
    end
  endtask

  task automatic test_rotation();
    int w;
    apply_reset();
    bus.req    = 3'b111;
    bus.req_op = 3'b101;
    for (int i = 0; i < 6; i++) begin
      serve(int'($urandom_range(1, 20)), i == 5, 0, w);
      if (i > 0) begin
        tests_run++;
        if (w !== 1) begin
          tests_failed++;
          $display("FAIL rotation_gap: got %0d extra cycles after IDLE want 1", w);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int w;
    apply_reset();
    bus.req    = 3'b001;
    bus.req_op = 3'b001;
    serve(0, 1'b1, 0, w);
    bus.req    = 3'b011;
    bus.req_op = 3'b010;
    serve(7, 1'b1, 0, w);
  endtask

  task automatic test_done_on_timeout();
    int w;
    apply_reset();
    bus.req    = 3'b100;
    bus.req_op = 3'b100;
    serve(T, 1'b1, 0, w);
    tests_run++;
    if (bus.err_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_on_timeout_sticky: got %b want 0", bus.err_sticky);
    end
  endtask

  task automatic test_ignore_changes();
    int w;
    apply_reset();
    bus.req    = 3'b010;
    bus.req_op = 3'b010;
    serve(10, 1'b1, 4, w);
    bus.req    = 3'b101;
    bus.req_op = 3'(($urandom));
    serve(3, 1'b1, 0, w);
  endtask

  task automatic test_reset_mid();
    int  w;
    bit  found;
    apply_reset();
    bus.req    = 3'b001;
    bus.req_op = 3'b001;
    found = 1'b0;
    for (int t = 0; t < 8 && !found; t++) begin
      tick();
      if (bus.unit_start === 1'b1) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL reset_mid_start: unit_start got 0 want 1 within 8 cycles");
    end
    for (int t = 0; t < 5; t++) tick();
    rst = 1'b1;
    bus.req = '0;
    tick();
    check_all_zero("reset_mid_drop");
    tick();
    check_all_zero("reset_mid_hold");
    rst    = 1'b0;
    m_rr   = 0;
    m_err  = 1'b0;
    bus.req    = 3'b100;
    bus.req_op = 3'b000;
    serve(4, 1'b1, 0, w);
  endtask

  task automatic test_random();
    int w;
    int r;
    int lat;
    apply_reset();
    for (int i = 0; i < 25; i++) begin
      bus.req    = 3'($urandom_range(1, 7));
      bus.req_op = 3'($urandom);
      r   = int'($urandom_range(0, 9));
      lat = (r == 0) ? 0 : (r == 1) ? T : int'($urandom_range(1, 25));
      serve(lat, 1'b1, 0, w);
      tests_run++;
      if (w !== 1) begin
        tests_failed++;
        $display("FAIL random_latency: iter %0d got %0d cycles want 1", i, w);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_rr         = 0;
    m_err        = 1'b0;
    rst          = 1'b1;
    bus.req       = '0;
    bus.req_op    = '0;
    bus.unit_done = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_done_on_timeout();
    test_ignore_changes();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/matrix_addsub_arbiter.md
Name: matrix_addsub_arbiter

Overview:
Round-robin controller that shares one element-wise matrix add/subtract unit between several EKF pipeline stages, such as the innovation (z - H*x) and covariance-update requesters. It grants one requester at a time and issues the start pulse and operation select to the unit. It waits for the unit's done, then returns a done or error pulse to the granted requester. A watchdog aborts transactions the unit never completes. Operand and result muxing live at the top level and are steered by grant_idx.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort (must exceed unit latency; 4x4 unit needs 18)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request level; held until req_done or req_err
req_op  in  NUM_REQ  per-requester op: 0 = subtract (A-B), 1 = add (A+B)
grant  out  NUM_REQ  one-hot grant, held from ISSUE through RESP
grant_idx  out  $clog2(NUM_REQ)  index of current or last grantee (operand mux select)
req_done  out  NUM_REQ  one-cycle pulse to grantee on successful completion
req_err  out  NUM_REQ  one-cycle pulse to grantee on timeout
unit_start  out  1  one-cycle start to shared unit
unit_op  out  1  op latched from grantee, stable ISSUE..RESP
unit_done  in  1  unit completion pulse
unit_abort  out  1  one-cycle pulse on timeout; top level ORs it into the unit's reset
busy  out  1  high in any state other than IDLE
err_sticky  out  1  set on any timeout, cleared only by rst

Behaviour:
- Reset (synchronous on rst): state=IDLE; grant, req_done, req_err, unit_start, unit_op, unit_abort, busy, err_sticky = 0; grant_idx = 0; rr_ptr = 0; timer = 0. rst asserted mid-transaction drops everything next edge with no done or err pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: if any req bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Register grant, grant_idx and unit_op=req_op[sel], then go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): unit_start=1, timer cleared, then go to WAIT. unit_done is ignored in ISSUE.
- WAIT:
  - unit_done=1: go to RESP with ok.
  - Otherwise timer++. When timer reaches TIMEOUT_CYCLES-1 without unit_done, go to RESP with error.
  - If unit_done and the timeout fall in the same cycle, done wins.
- RESP (1 cycle): pulse req_done[grant_idx] (ok) or req_err[grant_idx] plus unit_abort, and set err_sticky (error). Set rr_ptr = (grant_idx+1) mod NUM_REQ, clear grant, return to IDLE.
- Latency: req sampled in IDLE at edge N gives grant/unit_start high in cycle N+1. unit_done in cycle M gives req_done in cycle M+1. Minimum gap between consecutive unit_start pulses is 3 cycles after unit_done (RESP, IDLE, ISSUE).
- req or req_op changes while granted are ignored; the transaction completes and the pulse is still issued. Requests arriving during a transaction wait for IDLE.
- Fairness: a continuously requesting set is served in strict rotation, and no requester waits more than NUM_REQ-1 transactions.
- Stray unit_done outside WAIT is ignored.
- Exactly one bit of grant is high while busy, and none in IDLE. req_done and req_err are mutually exclusive and never multi-hot.

Test Plan:
- Single request: req=3'b001, op=0, unit model done 18 cycles after start -> grant=001 one cycle after req, unit_start 1 cycle, unit_op=0, req_done[0] pulse one cycle after unit_done, busy low afterwards.
- All three request continuously with op=1,0,1, rr_ptr=0 -> grants in order 0,1,2,0,1,2; unit_op follows 1,0,1; exactly 3 cycles between unit_done and the next unit_start.
- Unit never responds, TIMEOUT_CYCLES=64 -> after 64 WAIT cycles, req_err[grantee] plus unit_abort pulse together and err_sticky=1; next requester is served normally.
- unit_done arrives on the timeout cycle -> req_done asserted, no req_err, no unit_abort, err_sticky stays 0.
- Requester 1 drops req and flips req_op mid-WAIT -> unit_op unchanged, req_done[1] still pulses, rr_ptr=2.
- rst asserted in WAIT -> next cycle all outputs 0, no pulses; an immediate new req=3'b100 gets grant=100 (rr_ptr reset to 0).
